// File: rtl/ls_mem_stage.sv
// Load/store stage: runs one data-memory transaction per instruction, aligns load data,
// and hands the result to LS/WB over a valid/ready handshake.
module ls_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_mem_rd,
    input  logic            in_mem_wr,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_exu_res,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [1:0]      in_wbctl,
    input  logic            in_rd_ena,
    input  logic [4:0]      in_rd_addr,
    input  logic            ie_flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_exu_res,
    output logic [1:0]      out_wbctl,
    output logic [XLEN-1:0] out_wbdata,
    output logic            out_rd_ena,
    output logic [4:0]      out_rd_addr,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic [4:0]      fwd_rd_addr,
    output logic [XLEN-1:0] fwd_rd_data,
    output logic            fwd_busy,
    output logic            misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic            drop, drop_next;
    logic            is_load;
    logic [2:0]      funct3;
    logic            capture, mem_op, mis;
    logic [XLEN-1:0] lane_wdata, shifted, load_data;
    logic [3:0]      lane_wstrb;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign capture   = in_valid && in_ready && !ie_flush;
    assign mem_op    = in_mem_rd || in_mem_wr;
    assign mis       = mem_op && ((in_funct3[1:0] == 2'b01 && in_exu_res[0]) ||
                                  (in_funct3[1:0] == 2'b10 && in_exu_res[1:0] != 2'b00));
    assign out_valid = (state == DONE);
    assign dmem_req_valid = (state == REQ);

    assign fwd_rd_addr = (state != IDLE && out_rd_ena) ? out_rd_addr : 5'd0;
    assign fwd_rd_data = (is_load && state == DONE) ? out_wbdata : out_exu_res;
    assign fwd_busy    = is_load && (state == REQ || state == WAIT);

    always_comb begin
        lane_wdata = in_wdata;
        lane_wstrb = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{in_wdata[7:0]}};
                lane_wstrb = 4'b0001 << in_exu_res[1:0];
            end
            2'b01: begin
                lane_wdata = {2{in_wdata[15:0]}};
                lane_wstrb = 4'b0011 << in_exu_res[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = dmem_resp_rdata >> {out_exu_res[1:0], 3'b000};
        load_data = shifted;
        case (funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

    // drop marks a transaction the memory already accepted but whose response must be swallowed
    always_comb begin
        state_next = state;
        drop_next  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (capture)
                    state_next = (mem_op && !mis) ? REQ : DONE;
                else if (state == DONE && (ie_flush || out_ready))
                    state_next = IDLE;
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_next = WAIT;
                    drop_next  = ie_flush;
                end else if (ie_flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (dmem_resp_valid)
                    state_next = (drop || ie_flush) ? IDLE : DONE;
                else
                    drop_next = drop || ie_flush;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_inst       <= '0;
            out_pc         <= '0;
            out_exu_res    <= '0;
            out_wbctl      <= '0;
            out_wbdata     <= '0;
            out_rd_ena     <= 1'b0;
            out_rd_addr    <= '0;
            is_load        <= 1'b0;
            funct3         <= '0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_wstrb <= '0;
            misalign       <= 1'b0;
        end else begin
            misalign <= capture && mis;
            if (capture) begin
                out_inst       <= in_inst;
                out_pc         <= in_pc;
                out_exu_res    <= in_exu_res;
                out_wbctl      <= in_wbctl;
                out_wbdata     <= '0;
                out_rd_ena     <= in_rd_ena && !mis;
                out_rd_addr    <= in_rd_addr;
                is_load        <= in_mem_rd;
                funct3         <= in_funct3;
                dmem_req_we    <= in_mem_wr;
                dmem_req_addr  <= {in_exu_res[XLEN-1:2], 2'b00};
                dmem_req_wdata <= lane_wdata;
                dmem_req_wstrb <= in_mem_wr ? lane_wstrb : 4'b0000;
            end else if (ie_flush) begin
                out_rd_ena <= 1'b0;
                out_inst   <= '0;
            end else if (state == WAIT && dmem_resp_valid && is_load && !drop) begin
                out_wbdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_ls_mem_stage.sv
// Scoreboard bench for ls_mem_stage: expected results are queued at issue and
// compared by a monitor whenever LS/WB accepts a result.
module tb_ls_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mem_rd, in_mem_wr, in_rd_ena, ie_flush;
    logic [31:0] in_inst, in_pc, in_exu_res, in_wdata;
    logic [2:0]  in_funct3;
    logic [1:0]  in_wbctl, out_wbctl;
    logic [4:0]  in_rd_addr, out_rd_addr, fwd_rd_addr;
    logic        out_valid, out_ready, out_rd_ena;
    logic [31:0] out_inst, out_pc, out_exu_res, out_wbdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_resp_valid;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata, fwd_rd_data;
    logic [3:0]  dmem_req_wstrb;
    logic        fwd_busy, misalign;

    typedef struct packed {
        logic [31:0] exu_res;
        logic [31:0] wbdata;
        logic        rd_ena;
        logic [4:0]  rd_addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] LD_ADDR  [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                             32'h8000_0002, 32'h8000_0000, 32'h8000_0001};
    localparam logic [2:0]  LD_F3    [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    localparam logic [31:0] LD_RDATA [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                                             32'h80FF_0000, 32'hCAFE_F00D, 32'h0000_7F80};
    localparam logic [31:0] LD_EXP   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                             32'h0000_80FF, 32'hCAFE_F00D, 32'h0000_007F};

    localparam logic [31:0] ST_ADDR  [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
    localparam logic [2:0]  ST_F3    [3] = '{3'b001, 3'b000, 3'b010};
    localparam logic [31:0] ST_DATA  [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0F0F};
    localparam logic [31:0] ST_LANES [3] = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hA5A5_0F0F};
    localparam logic [3:0]  ST_STRB  [3] = '{4'b1100, 4'b0010, 4'b1111};
    localparam logic [31:0] ST_WADDR [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};

    initial forever #5 clk = ~clk;

    ls_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3),
        .in_exu_res(in_exu_res), .in_wdata(in_wdata), .in_wbctl(in_wbctl),
        .in_rd_ena(in_rd_ena), .in_rd_addr(in_rd_addr), .ie_flush(ie_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_exu_res(out_exu_res), .out_wbctl(out_wbctl), .out_wbdata(out_wbdata),
        .out_rd_ena(out_rd_ena), .out_rd_addr(out_rd_addr),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .fwd_rd_addr(fwd_rd_addr), .fwd_rd_data(fwd_rd_data), .fwd_busy(fwd_busy),
        .misalign(misalign)
    );

    // A result leaves the stage on every cycle with out_valid && out_ready (and no flush)
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && ie_flush === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_out got exu=%h wb=%h want no result", out_exu_res, out_wbdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_exu_res, out_wbdata, out_rd_ena, out_rd_addr} !== mon_e) begin
                    errors++;
                    $display("[TB] FAIL scoreboard got exu=%h wb=%h rd_ena=%b rd=%0d want exu=%h wb=%h rd_ena=%b rd=%0d",
                             out_exu_res, out_wbdata, out_rd_ena, out_rd_addr,
                             mon_e.exu_res, mon_e.wbdata, mon_e.rd_ena, mon_e.rd_addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] exu, input logic [31:0] wdata, input logic rd,
                        input logic wr, input logic [2:0] f3, input logic rena, input logic [4:0] rda);
        int n = 0;
        in_inst    = 32'hA000_0000 | {16'd0, exu[15:0]};
        in_pc      = 32'h0000_1000;
        in_exu_res = exu;
        in_wdata   = wdata;
        in_mem_rd  = rd;
        in_mem_wr  = wr;
        in_funct3  = f3;
        in_wbctl   = 2'b01;
        in_rd_ena  = rena;
        in_rd_addr = rda;
        in_valid   = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_exu_res = 32'hFFFF_FFFF;
        in_wdata   = 32'h0BAD_0BAD;
    endtask

    task automatic do_mem(input logic [31:0] rdata);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_rdata = rdata;
        dmem_resp_valid = 1'b1;
        step();
        dmem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %b want 0", dmem_req_valid); end
        if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b want 0", misalign); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        if ({out_wbdata, out_rd_ena} !== 33'd0) begin errors++; $display("[TB] FAIL reset_out_regs got %h want 0", {out_wbdata, out_rd_ena}); end
        if (fwd_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_fwd_busy got %b want 0", fwd_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        out_ready = 1'b1;
        exp_q.push_back({32'h0000_1234, 32'd0, 1'b1, 5'd5});
        send(32'h0000_1234, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_latency got out_valid=%b want 1", out_valid); end
        if (fwd_rd_addr !== 5'd5) begin errors++; $display("[TB] FAIL alu_fwd_addr got %0d want 5", fwd_rd_addr); end
        if (fwd_rd_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_fwd_data got %h want 00001234", fwd_rd_data); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_loads();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({LD_ADDR[i], LD_EXP[i], 1'b1, 5'(10 + i)});
            send(LD_ADDR[i], 32'd0, 1'b1, 1'b0, LD_F3[i], 1'b1, 5'(10 + i));
            checks += 3;
            if (dmem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_req_valid[%0d] got %b want 1", i, dmem_req_valid); end
            if ({dmem_req_we, dmem_req_addr} !== {1'b0, 32'h8000_0000}) begin
                errors++; $display("[TB] FAIL load_req[%0d] got we=%b addr=%h want we=0 addr=80000000", i, dmem_req_we, dmem_req_addr);
            end
            if (fwd_busy !== 1'b1) begin errors++; $display("[TB] FAIL load_fwd_busy[%0d] got %b want 1", i, fwd_busy); end
            do_mem(LD_RDATA[i]);
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_latency[%0d] got out_valid=%b want 1", i, out_valid); end
            if (fwd_rd_data !== LD_EXP[i]) begin errors++; $display("[TB] FAIL load_fwd_data[%0d] got %h want %h", i, fwd_rd_data, LD_EXP[i]); end
            step();
        end
    endtask

    task automatic test_store();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({ST_ADDR[i], 32'd0, 1'b0, 5'd0});
            send(ST_ADDR[i], ST_DATA[i], 1'b0, 1'b1, ST_F3[i], 1'b0, 5'd0);
            checks += 2;
            if ({dmem_req_valid, dmem_req_we, fwd_busy} !== 3'b110) begin
                errors++; $display("[TB] FAIL store_ctl[%0d] got valid/we/busy=%b want 110", i, {dmem_req_valid, dmem_req_we, fwd_busy});
            end
            if ({dmem_req_addr, dmem_req_wdata, dmem_req_wstrb} !== {ST_WADDR[i], ST_LANES[i], ST_STRB[i]}) begin
                errors++; $display("[TB] FAIL store_lanes[%0d] got addr=%h wdata=%h wstrb=%b want addr=%h wdata=%h wstrb=%b",
                                   i, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, ST_WADDR[i], ST_LANES[i], ST_STRB[i]);
            end
            do_mem(32'd0);
            step();
        end
    endtask

    task automatic test_misalign();
        out_ready = 1'b1;
        exp_q.push_back({32'h8000_0002, 32'd0, 1'b0, 5'd9});
        send(32'h8000_0002, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9);
        checks += 2;
        if ({misalign, dmem_req_valid, out_valid, out_rd_ena} !== 4'b1010) begin
            errors++; $display("[TB] FAIL misalign_lw got mis/req/valid/rd_ena=%b want 1010", {misalign, dmem_req_valid, out_valid, out_rd_ena});
        end
        if (fwd_rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL misalign_fwd got %0d want 0", fwd_rd_addr); end
        step();
        checks++;
        if ({misalign, dmem_req_valid} !== 2'b00) begin errors++; $display("[TB] FAIL misalign_pulse got %b want 00", {misalign, dmem_req_valid}); end
        exp_q.push_back({32'h8000_0001, 32'd0, 1'b0, 5'd0});
        send(32'h8000_0001, 32'h1111_2222, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0);
        checks++;
        if ({misalign, dmem_req_valid, out_valid} !== 3'b101) begin
            errors++; $display("[TB] FAIL misalign_sh got mis/req/valid=%b want 101", {misalign, dmem_req_valid, out_valid});
        end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        exp_q.push_back({32'h8000_0008, 32'h1234_5678, 1'b1, 5'd12});
        send(32'h8000_0008, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd12);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dmem_req_valid, dmem_req_we, dmem_req_addr, fwd_busy, fwd_rd_addr} !== {2'b10, 32'h8000_0008, 1'b1, 5'd12}) begin
                errors++; $display("[TB] FAIL stall_hold[%0d] got valid=%b we=%b addr=%h busy=%b fwd_rd=%0d want 1 0 80000008 1 12",
                                   i, dmem_req_valid, dmem_req_we, dmem_req_addr, fwd_busy, fwd_rd_addr);
            end
            step();
        end
        do_mem(32'h1234_5678);
        checks++;
        if (out_wbdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL stall_wbdata got %h want 12345678", out_wbdata); end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(32'h8000_0010, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd13);
        ie_flush = 1'b1;
        step();
        ie_flush = 1'b0;
        checks++;
        if ({dmem_req_valid, out_valid, in_ready} !== 3'b001) begin
            errors++; $display("[TB] FAIL flush_req got req/valid/in_ready=%b want 001", {dmem_req_valid, out_valid, in_ready});
        end
        send(32'h8000_0014, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd14);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        ie_flush = 1'b1;
        step();
        ie_flush = 1'b0;
        dmem_resp_rdata = 32'h5555_AAAA;
        dmem_resp_valid = 1'b1;
        step();
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++; $display("[TB] FAIL flush_wait[%0d] got valid/in_ready=%b want 01", i, {out_valid, in_ready});
            end
            step();
        end
        out_ready = 1'b0;
        send(32'h0000_0042, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd15);
        ie_flush = 1'b1;
        step();
        ie_flush = 1'b0;
        checks++;
        if ({out_valid, out_rd_ena, out_inst} !== 34'd0) begin
            errors++; $display("[TB] FAIL flush_done got valid=%b rd_ena=%b inst=%h want 0 0 0", out_valid, out_rd_ena, out_inst);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        exp_q.push_back({32'h0000_AAAA, 32'd0, 1'b1, 5'd7});
        send(32'h0000_AAAA, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd7);
        in_exu_res = 32'h0000_BBBB;
        in_rd_addr = 5'd8;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, out_exu_res} !== {2'b01, 32'h0000_AAAA}) begin
                errors++; $display("[TB] FAIL backpressure[%0d] got in_ready=%b valid=%b exu=%h want 0 1 0000aaaa", i, in_ready, out_valid, out_exu_res);
            end
            step();
        end
        out_ready = 1'b1;
        exp_q.push_back({32'h0000_BBBB, 32'd0, 1'b1, 5'd8});
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_exu_res} !== {1'b1, 32'h0000_BBBB}) begin
            errors++; $display("[TB] FAIL b2b_no_bubble got valid=%b exu=%h want 1 0000bbbb", out_valid, out_exu_res);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        {in_valid, in_mem_rd, in_mem_wr, in_rd_ena, ie_flush, out_ready} = '0;
        {in_inst, in_pc, in_exu_res, in_wdata} = '0;
        in_funct3 = '0; in_wbctl = '0; in_rd_addr = '0;
        {dmem_req_ready, dmem_resp_valid} = '0;
        dmem_resp_rdata = '0;
        test_reset();
        test_alu();
        test_loads();
        test_store();
        test_misalign();
        test_stall();
        test_flush();
        test_back_to_back();
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
